// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of an asynchronous PWM input in clk cycles.
// Optional glitch filter enabled by defining PWM_CAPTURE_FILT_EN.
module pwm_capture #(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             meas_valid,
    output logic             timeout,
    output logic             stuck_level
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    // Unsupported configurations elaborate to nothing extra; the chain below assumes >= 2 stages.
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || FILT_LEN < 1) begin : g_param_range
    end

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync;
    logic                   w_level;
    logic                   r_s_d;
    logic                   w_rise;
    logic                   w_fall;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [CNT_W-1:0]       r_high_hold;
    logic [CNT_W-1:0]       w_high_hold_nxt;
    logic                   w_sat;
    logic                   w_report;
    logic                   w_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pwm_in};
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_FILT_EN
    localparam int FW = $clog2(FILT_LEN + 1);

    logic [FW-1:0] r_filt_cnt;
    logic          r_filt;

    // Level flips only once the synchronized input has disagreed for FILT_LEN consecutive cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_filt_cnt <= '0;
            r_filt     <= 1'b0;
        end else if (w_sync == r_filt) begin
            r_filt_cnt <= '0;
        end else if (r_filt_cnt == FW'(FILT_LEN - 1)) begin
            r_filt_cnt <= '0;
            r_filt     <= w_sync;
        end else begin
            r_filt_cnt <= r_filt_cnt + 1'b1;
        end
    end

    assign w_level = r_filt;
`else
    assign w_level = w_sync;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s_d <= 1'b0;
        end else begin
            r_s_d <= w_level;
        end
    end

    assign w_rise = w_level & ~r_s_d;
    assign w_fall = ~w_level & r_s_d;
    assign w_sat  = (r_cnt == '1);

    // cnt is 1 on the cycle after a rise, so at any later edge it equals cycles since that rise.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_high_hold_nxt = r_high_hold;
        w_report        = 1'b0;
        w_timeout       = 1'b0;

        if (!en) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_cnt_nxt = '0;
                    if (w_rise) begin
                        w_cnt_nxt   = CNT_W'(1);
                        w_state_nxt = HIGH;
                    end
                end
                HIGH: begin
                    if (w_fall) begin
                        w_high_hold_nxt = r_cnt;
                        w_state_nxt     = LOW;
                        w_cnt_nxt       = w_sat ? r_cnt : r_cnt + 1'b1;
                    end else if (w_sat) begin
                        w_timeout   = 1'b1;
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                LOW: begin
                    if (w_rise) begin
                        w_report    = 1'b1;
                        w_cnt_nxt   = CNT_W'(1);
                        w_state_nxt = HIGH;
                    end else if (w_sat) begin
                        w_timeout   = 1'b1;
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_high_hold <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_high_hold <= w_high_hold_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_out  <= '0;
            high_out    <= '0;
            meas_valid  <= 1'b0;
            timeout     <= 1'b0;
            stuck_level <= 1'b0;
        end else begin
            meas_valid <= w_report;
            timeout    <= w_timeout;
            if (w_report) begin
                period_out <= r_cnt;
                high_out   <= r_high_hold;
            end
            if (w_timeout) begin
                stuck_level <= w_level;
            end
        end
    end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Receive-side counterpart of the PWM generator. It measures an incoming PWM waveform and reports its period and high time in clock cycles, plus a timeout flag for a stuck input.
- Used for loopback checking of motor-drive PWM and for decoding externally supplied PWM command/feedback signals in the motion controller.
- Counts are in the same CNT_W-bit domain as the generator's duty/period values, so a capture compares directly against the programmed duty.

Parameters:
- CNT_W, 8, width of period/high counters and outputs
- SYNC_STAGES, 2, number of input synchronizer flops (legal range 2..4)
- FILT_LEN, 3, stable-sample count for the glitch filter (used only with PWM_CAPTURE_FILT_EN)

Ports:
- clk  in  1  system clock, rising-edge active
- rst_n  in  1  asynchronous active-low reset
- en  in  1  capture enable; low forces IDLE
- pwm_in  in  1  asynchronous PWM input
- period_out  out  CNT_W  last measured period, in clk cycles
- high_out  out  CNT_W  last measured high time, in clk cycles
- meas_valid  out  1  one-cycle pulse when period_out/high_out update
- timeout  out  1  one-cycle pulse when the counter saturates without an edge
- stuck_level  out  1  synchronized pwm_in level captured at the last timeout

Behaviour:
- Reset (rst_n low, asynchronous): all synchronizer/filter flops, the edge register, the counter and the high-time holding register clear to 0. State goes to IDLE. All outputs are 0.
- Input path:
  - pwm_in passes through SYNC_STAGES flops, then a one-flop edge register.
  - rise = s & ~s_d; fall = ~s & s_d.
  - Edge detection latency from pwm_in is SYNC_STAGES+1 cycles. This latency does not affect measured values.
- Counter cnt:
  - Set to 1 on the cycle after a rise event.
  - Otherwise increments by 1 each cycle while in HIGH or LOW.
  - Saturates at 2^CNT_W-1.
- Timing relations:
  - high time = t_fall - t_rise.
  - period = t_rise(n+1) - t_rise(n).
- States:
  - IDLE: wait for rise.
    - On rise: cnt<=1, go to HIGH.
  - HIGH:
    - On fall: high_hold<=cnt, go to LOW.
    - On saturation with no fall: go to IDLE.
  - LOW:
    - On rise: period_out<=cnt, high_out<=high_hold, meas_valid=1 next cycle, cnt<=1, go to HIGH.
    - On saturation with no rise: go to IDLE.
- Saturation: cnt == 2^CNT_W-1 with no terminating edge in that cycle.
  - timeout pulses 1 cycle and stuck_level<=s.
  - period_out/high_out hold their previous values. No meas_valid.
- Measurement start: the first meas_valid occurs only after two rises (one full period). Any partial period after reset, enable or timeout is discarded.
- Simultaneous events:
  - A rise in the same cycle as saturation counts as an edge, not a timeout.
  - rise and fall cannot coincide by construction.
- en low: state goes to IDLE and cnt clears. Outputs hold and no pulses are issued. The synchronizer keeps running, so s_d stays current and no false edge appears on re-enable.
- rst_n asserted mid-measurement: the measurement is aborted and outputs clear immediately.
- Value limits:
  - period_out >= 2. A period of 1 is impossible after synchronization.
  - high_out ranges 1..period_out-1.

Optional Feature:
- Macro: PWM_CAPTURE_FILT_EN.
- Defined:
  - A glitch filter sits between the synchronizer and the edge register.
  - The filtered level changes only after the synchronized input has held the new value for FILT_LEN consecutive cycles.
  - Pulses shorter than FILT_LEN cycles are ignored.
  - Added latency is FILT_LEN cycles, identical on both edges, so measured values are unchanged for pulses >= FILT_LEN.
  - The filter counter resets to 0 and the filtered level resets to 0.
- Undefined: there is no filter. The synchronized level feeds the edge register directly.

Test Plan:
- Input and check: CNT_W=8; pwm_in period 100, high 25, repeated 5 periods. Require period_out=100 and high_out=25 with meas_valid once per period. The first meas_valid is at the second rise + SYNC_STAGES+2 cycles.
- Duty change: period 100, high changes 25->60 at a period boundary. Require the next report 100/60 and no intermediate bogus values.
- Stuck input: pwm_in held high for 300 cycles after one rise. Require timeout to pulse once at cnt=255, stuck_level=1, no meas_valid, and outputs held. Normal PWM resuming must give a valid report after two rises.
- Enable and reset abort:
  - Deassert en mid-HIGH, then reassert. Require no meas_valid until two fresh rises.
  - Assert rst_n low mid-LOW. Require all outputs 0 immediately, asynchronously and without a clock edge.
- Filter: with PWM_CAPTURE_FILT_EN and FILT_LEN=3, inject 2-cycle glitches low inside a 40-cycle high time (period 80). Require high_out=40 and period_out=80. Without the macro, the same stimulus must yield shortened high_out.
